weight_tile_scheduler: RTL and testbench

- Sequences the weight controller across a whole layer.
- Walks every (output-depth pair, input-depth) tile and drives the od/id indices and the prepare/start handshake.
- Waits for each transformed weight tile to finish, then hands it to the PE arrays with a valid/ready handshake.
- Sits between the main controller (start/done, config) and the weight controller / PE array.

---
 rtl/weight_tile_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_weight_tile_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_tile_scheduler.sv
// Layer-level scheduler: walks (od pair, id) weight tiles, handshakes with the weight controller and PE arrays.
// Optional watchdog on the wait states is compiled in with `define WEIGHT_SCHED_TIMEOUT_EN.
module weight_tile_scheduler #(
  parameter int unsigned ID_W           = 5,
  parameter int unsigned OD_W           = 8,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wen_i,
  input  logic [ID_W-1:0]  total_id_i,
  input  logic [OD_W-1:0]  total_od_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [OD_W-1:0]  weight_od1_o,
  output logic [OD_W-1:0]  weight_od2_o,
  output logic             od2_valid_o,
  output logic [3:0]       weight_id_o,
  output logic             weight_prepare_o,
  output logic             weight_start_o,
  input  logic             weight_ready_i,
  input  logic             weight_finished_i,
  output logic             pe_valid_o,
  input  logic             pe_ready_i,
  output logic [CNT_W-1:0] tile_count_o,
  output logic             error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_WAIT_RDY,
    S_START,
    S_WAIT_FIN,
    S_ISSUE,
    S_DONE
`ifdef WEIGHT_SCHED_TIMEOUT_EN
    , S_ERROR
`endif
  } state_t;

  localparam logic [ID_W-1:0] ID_MAX   = ID_W'(16);
  localparam logic [ID_W-1:0] ID_ONE   = ID_W'(1);
  localparam logic [OD_W-1:0] OD_ONE   = OD_W'(1);
  localparam logic [OD_W-1:0] OD_TWO   = OD_W'(2);
  localparam logic [OD_W:0]   ODX_ONE  = (OD_W+1)'(1);
  localparam logic [OD_W:0]   ODX_TWO  = (OD_W+1)'(2);

  state_t            state, state_d;
  logic [ID_W-1:0]   cfg_id, pass_id, id_cnt;
  logic [OD_W-1:0]   cfg_od, pass_od, od_cnt;
  logic [CNT_W-1:0]  tile_count;
  logic              load_pass, xfer, last_id, last_tile, in_pass, wd_expired;

  // Pass config is snapshotted at start so a same-cycle config write only affects the next pass.
  assign last_id   = (id_cnt == pass_id - ID_ONE);
  assign last_tile = last_id && (({1'b0, od_cnt} + ODX_TWO) >= {1'b0, pass_od});
  assign in_pass   = (state == S_PREP) || (state == S_WAIT_RDY) || (state == S_START) ||
                     (state == S_WAIT_FIN) || (state == S_ISSUE);

`ifdef WEIGHT_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state_d != state) begin
      wd_cnt <= '0;
    end else if ((state == S_WAIT_RDY) || (state == S_WAIT_FIN)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign error_o    = (state == S_ERROR);
`else
  assign wd_expired = 1'b0;
  assign error_o    = 1'b0;
`endif

  always_comb begin
    state_d          = state;
    load_pass        = 1'b0;
    xfer             = 1'b0;
    weight_prepare_o = 1'b0;
    weight_start_o   = 1'b0;
    pe_valid_o       = 1'b0;
    done_o           = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          if ((cfg_id == '0) || (cfg_od == '0)) begin
            state_d = S_DONE;
          end else begin
            load_pass = 1'b1;
            state_d   = S_PREP;
          end
        end
      end
      S_PREP: begin
        weight_prepare_o = 1'b1;
        state_d          = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (weight_ready_i) begin
          state_d = S_START;
        end else if (wd_expired) begin
`ifdef WEIGHT_SCHED_TIMEOUT_EN
          state_d = S_ERROR;
`endif
        end
      end
      S_START: begin
        weight_start_o = 1'b1;
        state_d        = S_WAIT_FIN;
      end
      S_WAIT_FIN: begin
        if (weight_finished_i) begin
          state_d = S_ISSUE;
        end else if (wd_expired) begin
`ifdef WEIGHT_SCHED_TIMEOUT_EN
          state_d = S_ERROR;
`endif
        end
      end
      S_ISSUE: begin
        pe_valid_o = 1'b1;
        if (pe_ready_i) begin
          xfer    = 1'b1;
          state_d = last_tile ? S_DONE : S_PREP;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = state;
    endcase
    if (abort_i && (state != S_IDLE)) begin
      state_d   = S_IDLE;
      xfer      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_id <= '0;
      cfg_od <= '0;
    end else if ((state == S_IDLE) && wen_i) begin
      cfg_id <= (total_id_i > ID_MAX) ? ID_MAX : total_id_i;
      cfg_od <= total_od_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_id    <= '0;
      pass_od    <= '0;
      id_cnt     <= '0;
      od_cnt     <= '0;
      tile_count <= '0;
    end else begin
      if (load_pass) begin
        pass_id <= cfg_id;
        pass_od <= cfg_od;
        id_cnt  <= '0;
        od_cnt  <= '0;
      end else if (xfer && !last_tile) begin
        if (last_id) begin
          id_cnt <= '0;
          od_cnt <= od_cnt + OD_TWO;
        end else begin
          id_cnt <= id_cnt + ID_ONE;
        end
      end
      if ((state == S_IDLE) && start_i) begin
        tile_count <= '0;
      end else if (xfer) begin
        tile_count <= tile_count + CNT_W'(1);
      end
    end
  end

  assign busy_o       = (state != S_IDLE);
  assign tile_count_o = tile_count;
  assign weight_od1_o = in_pass ? od_cnt : '0;
  assign weight_od2_o = in_pass ? (od_cnt + OD_ONE) : '0;
  assign od2_valid_o  = in_pass && (({1'b0, od_cnt} + ODX_ONE) < {1'b0, pass_od});
  assign weight_id_o  = in_pass ? id_cnt[3:0] : '0;

endmodule

// File: tb/tb_weight_tile_scheduler.sv
// Directed, table-driven bench for weight_tile_scheduler (default build, watchdog not compiled in).
module tb_weight_tile_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wen_i = 1'b0;
  logic [4:0] total_id_i = '0;
  logic [7:0] total_od_i = '0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       busy_o, done_o, od2_valid_o, weight_prepare_o, weight_start_o;
  logic [7:0] weight_od1_o, weight_od2_o;
  logic [3:0] weight_id_o;
  logic       weight_ready_i = 1'b0;
  logic       weight_finished_i = 1'b0;
  logic       pe_valid_o;
  logic       pe_ready_i = 1'b0;
  logic [15:0] tile_count_o;
  logic       error_o;

  int errors = 0;
  int checks = 0;

  weight_tile_scheduler #(
    .ID_W(5), .OD_W(8), .CNT_W(16), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk), .reset(reset), .wen_i(wen_i), .total_id_i(total_id_i),
    .total_od_i(total_od_i), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .weight_od1_o(weight_od1_o),
    .weight_od2_o(weight_od2_o), .od2_valid_o(od2_valid_o),
    .weight_id_o(weight_id_o), .weight_prepare_o(weight_prepare_o),
    .weight_start_o(weight_start_o), .weight_ready_i(weight_ready_i),
    .weight_finished_i(weight_finished_i), .pe_valid_o(pe_valid_o),
    .pe_ready_i(pe_ready_i), .tile_count_o(tile_count_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_timeout: actual=stuck required=finish");
    $fatal(1);
  end

  typedef struct {
    int od;
    int id;
    int stall;
    int exp_tiles;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // wmode 0: use existing config; 1: write od/id before start; 2: write od_w/id_w in the start cycle.
  task automatic run_pass(input int od, input int id, input int stall, input int wmode,
                          input int od_w, input int id_w, input int exp_tiles, input int tag);
    int eff_id, e_od, e_id, tiles, preps, starts, rdy_t, fin_t, stall_left;
    int cyc, last_xfer, done_cyc;
    bit done_seen;
    eff_id = (id > 16) ? 16 : id;
    e_od = 0; e_id = 0; tiles = 0; preps = 0; starts = 0; rdy_t = 0; fin_t = 0;
    stall_left = stall; last_xfer = 0; done_cyc = 0; done_seen = 1'b0;
    if (wmode == 1) begin
      total_od_i = 8'(od); total_id_i = 5'(id); wen_i = 1'b1;
      @(negedge clk);
      wen_i = 1'b0;
    end
    start_i = 1'b1;
    if (wmode == 2) begin
      total_od_i = 8'(od_w); total_id_i = 5'(id_w); wen_i = 1'b1;
    end
    @(negedge clk);
    start_i = 1'b0; wen_i = 1'b0;
    cyc = 1;
    while (!done_seen && cyc < 3000) begin
      weight_ready_i = 1'b0; weight_finished_i = 1'b0; pe_ready_i = 1'b0;
      if (done_o) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end else begin
        if (weight_prepare_o) begin preps++; rdy_t = 3; end
        if (weight_start_o)   begin starts++; fin_t = 3; end
        if (rdy_t > 0) begin rdy_t--; if (rdy_t == 0) weight_ready_i = 1'b1; end
        if (fin_t > 0) begin fin_t--; if (fin_t == 0) weight_finished_i = 1'b1; end
        if (pe_valid_o) begin
          chk($sformatf("v%0d t%0d od1", tag, tiles), weight_od1_o, e_od);
          chk($sformatf("v%0d t%0d od2", tag, tiles), weight_od2_o, e_od + 1);
          chk($sformatf("v%0d t%0d id", tag, tiles), weight_id_o, e_id);
          chk($sformatf("v%0d t%0d od2_valid", tag, tiles), od2_valid_o, (e_od + 1 < od) ? 1 : 0);
          if (stall_left > 0) begin
            stall_left--;
            chk($sformatf("v%0d t%0d stall_count", tag, tiles), tile_count_o, tiles);
          end else begin
            pe_ready_i = 1'b1;
            tiles++;
            last_xfer  = cyc;
            stall_left = stall;
            if (e_id == eff_id - 1) begin e_id = 0; e_od += 2; end
            else e_id++;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk($sformatf("v%0d done_seen", tag), done_seen, 1);
    if (exp_tiles > 0) chk($sformatf("v%0d done_latency", tag), done_cyc - last_xfer, 1);
    else               chk($sformatf("v%0d done_within2", tag), (done_cyc <= 2) ? 1 : 0, 1);
    chk($sformatf("v%0d tiles", tag), tiles, exp_tiles);
    chk($sformatf("v%0d prepares", tag), preps, exp_tiles);
    chk($sformatf("v%0d starts", tag), starts, exp_tiles);
    chk($sformatf("v%0d tile_count", tag), tile_count_o, exp_tiles);
    weight_ready_i = 1'b0; weight_finished_i = 1'b0; pe_ready_i = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d done_one_cycle", tag), done_o, 0);
    chk($sformatf("v%0d idle_busy", tag), busy_o, 0);
  endtask

  initial begin
    int n_start, n_valid, n_bad;
    bit aborted;

    vecs[0] = '{od: 4, id: 2,  stall: 0, exp_tiles: 4};
    vecs[1] = '{od: 3, id: 1,  stall: 0, exp_tiles: 2};
    vecs[2] = '{od: 0, id: 3,  stall: 0, exp_tiles: 0};
    vecs[3] = '{od: 2, id: 3,  stall: 5, exp_tiles: 3};
    vecs[4] = '{od: 5, id: 20, stall: 0, exp_tiles: 48};
    vecs[5] = '{od: 1, id: 0,  stall: 0, exp_tiles: 0};

    @(negedge clk);
    @(negedge clk);
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst pe_valid", pe_valid_o, 0);
    chk("rst od1", weight_od1_o, 0);
    chk("rst od2", weight_od2_o, 0);
    chk("rst od2_valid", od2_valid_o, 0);
    chk("rst id", weight_id_o, 0);
    chk("rst prepare", weight_prepare_o, 0);
    chk("rst start", weight_start_o, 0);
    chk("rst tile_count", tile_count_o, 0);
    chk("rst error", error_o, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_pass(vecs[i].od, vecs[i].id, vecs[i].stall, 1, 0, 0, vecs[i].exp_tiles, i);
    end

    // Abort in WAIT_FIN of tile 2, with a config write attempted mid-pass.
    total_od_i = 8'd4; total_id_i = 5'd2; wen_i = 1'b1;
    @(negedge clk);
    wen_i = 1'b0;
    weight_ready_i = 1'b1; weight_finished_i = 1'b1; pe_ready_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n_start = 0; n_valid = 0; aborted = 1'b0;
    for (int c = 0; c < 100 && !aborted; c++) begin
      if (weight_prepare_o && n_start == 0) begin
        total_od_i = 8'd2; total_id_i = 5'd1; wen_i = 1'b1;
      end else begin
        wen_i = 1'b0;
      end
      if (pe_valid_o) n_valid++;
      if (weight_start_o) begin
        n_start++;
        if (n_start == 2) begin
          @(negedge clk);
          wen_i = 1'b0; weight_finished_i = 1'b0; abort_i = 1'b1; aborted = 1'b1;
        end
      end
      @(negedge clk);
    end
    abort_i = 1'b0; wen_i = 1'b0;
    weight_ready_i = 1'b0; weight_finished_i = 1'b0; pe_ready_i = 1'b0;
    chk("abort reached", aborted, 1);
    chk("abort busy", busy_o, 0);
    chk("abort pe_valid", pe_valid_o, 0);
    chk("abort done", done_o, 0);
    chk("abort tiles_before", n_valid, 1);
    chk("abort tile_count", tile_count_o, 1);
    n_bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done_o || weight_prepare_o || weight_start_o || pe_valid_o || busy_o) n_bad++;
    end
    chk("abort quiet", n_bad, 0);

    // Config written mid-pass must have been dropped: still od=4, id=2.
    run_pass(4, 2, 0, 0, 0, 0, 4, 10);

    // Start and write together: this pass uses od=2,id=1, the next one od=4,id=2.
    run_pass(2, 1, 0, 1, 0, 0, 1, 11);
    run_pass(2, 1, 0, 2, 4, 2, 1, 12);
    run_pass(4, 2, 0, 0, 0, 0, 4, 13);

    chk("final error", error_o, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
